// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and flag indices for alu_pipe
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add unsigned multiplier, one partial product per cycle
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               run_q;

    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    // done fires alongside the final step so the product is taken from acc_d
    assign done = run_q && (cnt_q == CNT_W'(1));
    assign prod = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= CNT_W'(WIDTH);
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_W'(1);
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with registered result/flags and optional sequential MUL
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
);

    localparam int SHW = $clog2(WIDTH);

    state_t             state_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_result_q;
    logic [3:0]         out_flags_q;

    logic [WIDTH-1:0]   res_d;
    logic [3:0]         flags_d;
    logic [WIDTH:0]     ext;
    logic               c_d;
    logic               v_d;
    logic [SHW-1:0]     shamt;

    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_hi_nz;

    assign in_ready   = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !rst;
    assign accept     = in_valid && in_ready;
    assign mul_start  = accept && (in_op == OP_MUL) && (MUL_EN != 0);
    assign shamt      = in_b[SHW-1:0];
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign mul_hi_nz  = |mul_prod[2*WIDTH-1:WIDTH];

    // ext carries the extra bit that becomes carry, borrow or the last shifted-out bit
    always_comb begin
        ext   = '0;
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (in_op)
            OP_ADD: begin
                ext   = {1'b0, in_a} + {1'b0, in_b};
                res_d = ext[WIDTH-1:0];
                c_d   = ext[WIDTH];
                v_d   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (res_d[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                ext   = {1'b0, in_a} - {1'b0, in_b};
                res_d = ext[WIDTH-1:0];
                c_d   = ext[WIDTH];
                v_d   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (res_d[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND: res_d = in_a & in_b;
            OP_OR:  res_d = in_a | in_b;
            OP_XOR: res_d = in_a ^ in_b;
            OP_SHL: begin
                ext   = {1'b0, in_a} << shamt;
                res_d = ext[WIDTH-1:0];
                c_d   = ext[WIDTH];
            end
            OP_SHR: begin
                ext   = {in_a, 1'b0} >> shamt;
                res_d = ext[WIDTH:1];
                c_d   = ext[0];
            end
            default: res_d = '0;
        endcase
        flags_d        = '0;
        flags_d[FLG_Z] = (res_d == '0);
        flags_d[FLG_N] = res_d[WIDTH-1];
        flags_d[FLG_C] = c_d;
        flags_d[FLG_V] = v_d;
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clk   (clk),
                .rst   (rst),
                .start (mul_start),
                .a     (in_a),
                .b     (in_b),
                .done  (mul_done),
                .prod  (mul_prod)
            );
        end else begin : g_no_mul
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (mul_start) begin
                            state_q     <= ST_BUSY;
                            out_valid_q <= 1'b0;
                        end else begin
                            out_valid_q  <= 1'b1;
                            out_result_q <= res_d;
                            out_flags_q  <= flags_d;
                        end
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (mul_done) begin
                        state_q             <= ST_IDLE;
                        out_valid_q         <= 1'b1;
                        out_result_q        <= mul_prod[WIDTH-1:0];
                        out_flags_q[FLG_Z]  <= (mul_prod[WIDTH-1:0] == '0);
                        out_flags_q[FLG_N]  <= mul_prod[WIDTH-1];
                        out_flags_q[FLG_C]  <= mul_hi_nz;
                        out_flags_q[FLG_V]  <= mul_hi_nz;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed and streaming checks of alu_pipe at WIDTH=8 and WIDTH=32/MUL_EN=0
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [2:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_result;
    logic [3:0]  out_flags;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [31:0] w_in_a = '0;
    logic [31:0] w_in_b = '0;
    logic [2:0]  w_in_op = '0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b1;
    logic [31:0] w_out_result;
    logic [3:0]  w_out_flags;

    int n_tests = 0;
    int n_fail  = 0;

    alu_pipe #(.WIDTH(8), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    alu_pipe #(.WIDTH(32), .MUL_EN(0)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .in_op(w_in_op),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_result(w_out_result), .out_flags(w_out_flags)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent 8-bit reference built from signed/unsigned integer arithmetic
    function automatic logic [11:0] ref8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, r, sr, s;
        logic c, v;
        ua = a; ub = b;
        sa = a[7] ? ua - 256 : ua;
        sb = b[7] ? ub - 256 : ub;
        s  = ub % 8;
        c  = 1'b0; v = 1'b0; r = 0;
        case (op)
            3'd0: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            3'd1: begin r = ua - ub; c = (ua < ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua << s; c = (s != 0) && (((r >> 8) & 1) == 1); end
            3'd6: begin r = ua >> s; c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
            default: r = 0;
        endcase
        r = r & 255;
        return {r[7:0], (r == 0), r[7], c, v};
    endfunction

    task automatic single(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input logic [3:0] exp_flg);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
        check({tag, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " result"}, out_result, exp_res);
        check({tag, " flags"}, out_flags, exp_flg);
    endtask

    task automatic mul_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input logic [3:0] exp_flg);
        int  lat;
        bit  rdy_seen;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_MUL; in_a = a; in_b = b; out_ready = 1'b1;
        check({tag, " in_ready"}, in_ready, 1);
        lat = 0; rdy_seen = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0; in_a = 8'hFF; in_b = 8'hFF; in_op = OP_ADD;
            lat++;
            if (!out_valid && in_ready) rdy_seen = 1;
        end while (!out_valid && lat < 40);
        check({tag, " latency"}, lat, 9);
        check({tag, " in_ready while busy"}, rdy_seen, 0);
        check({tag, " result"}, out_result, exp_res);
        check({tag, " flags"}, out_flags, exp_flg);
    endtask

    task automatic w_single(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic [3:0] exp_flg);
        @(negedge clk);
        w_in_valid = 1'b1; w_in_op = op; w_in_a = a; w_in_b = b;
        check({tag, " in_ready"}, w_in_ready, 1);
        @(negedge clk);
        w_in_valid = 1'b0;
        check({tag, " out_valid"}, w_out_valid, 1);
        check({tag, " result"}, w_out_result, exp_res);
        check({tag, " flags"}, w_out_flags, exp_flg);
    endtask

    logic [11:0] exp_arr [100];
    logic [2:0]  s_op;
    logic [7:0]  s_a, s_b;
    bit          seen;

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset out_result", out_result, 0);
        check("reset out_flags", out_flags, 0);
        check("reset in_ready", in_ready, 0);
        check("reset w out_valid", w_out_valid, 0);
        rst = 1'b0;

        single("add F0+20", OP_ADD, 8'hF0, 8'h20, 8'h10, 4'b0010);
        single("sub 50-B0", OP_SUB, 8'h50, 8'hB0, 8'hA0, 4'b0111);
        single("shl 81 s1", OP_SHL, 8'h81, 8'h01, 8'h02, 4'b0010);
        single("shr 81 s3", OP_SHR, 8'h81, 8'h03, 8'h10, 4'b0000);
        single("shl 81 s0", OP_SHL, 8'h81, 8'h00, 8'h81, 4'b0100);
        single("shl 81 b09", OP_SHL, 8'h81, 8'h09, 8'h02, 4'b0010);
        single("and", OP_AND, 8'hF0, 8'h0F, 8'h00, 4'b1000);

        mul_op("mul 0F*11", 8'h0F, 8'h11, 8'hFF, 4'b0100);
        mul_op("mul 10*10", 8'h10, 8'h10, 8'h00, 4'b1011);

        // Backpressure: XOR result held while a pending ADD waits
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_XOR; in_a = 8'hA5; in_b = 8'h0F; out_ready = 1'b0;
        check("bp xor in_ready", in_ready, 1);
        @(negedge clk);
        in_op = OP_ADD; in_a = 8'h01; in_b = 8'h02;
        repeat (5) begin
            check("bp out_valid", out_valid, 1);
            check("bp result", out_result, 8'hAA);
            check("bp flags", out_flags, 4'b0100);
            check("bp in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp pending out_valid", out_valid, 1);
        check("bp pending result", out_result, 8'h03);
        check("bp pending flags", out_flags, 4'b0000);

        // Reset three cycles into a MUL
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_MUL; in_a = 8'h0F; in_b = 8'h11;
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("rst in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        check("rst out_valid", out_valid, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("aborted mul never emerges", seen, 0);
        single("post-rst add 1+1", OP_ADD, 8'h01, 8'h01, 8'h02, 4'b0000);

        // Streaming single-cycle ops at full throughput
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("stream %0d out_valid", i - 1), out_valid, 1);
                check($sformatf("stream %0d res/flags", i - 1), {out_result, out_flags}, exp_arr[i-1]);
            end
            if (i < 100) begin
                s_op = 3'($urandom_range(0, 6));
                s_a  = 8'($urandom);
                s_b  = 8'($urandom);
                exp_arr[i] = ref8(s_op, s_a, s_b);
                check($sformatf("stream %0d in_ready", i), in_ready, 1);
                in_valid = 1'b1; in_op = s_op; in_a = s_a; in_b = s_b;
            end else begin
                in_valid = 1'b0;
            end
        end

        w_single("w32 op111 zero", OP_MUL, 32'h0000_0005, 32'h0000_0007, 32'h0, 4'b1000);
        w_single("w32 add wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1010);
        w_single("w32 shr s31", OP_SHR, 32'h8000_0000, 32'h0000_001F, 32'h1, 4'b0000);
        w_single("w32 shl s31", OP_SHL, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 4'b0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
